day10_output_scheduler: RTL

- Round-robin scheduler that shares the single day10 output writer among NUM_LANES parallel solver lanes.
- Each lane presents one finished machine result at a time. The scheduler grants one lane, latches its result, and drives the writer's start and last_write.
- It waits for writer_ready, acknowledges the lane, and counts records until the job's record total is reached.
- It sits between the solver lane array and the output writer feeding the AXI-Stream result port.

---
 rtl/day10_output_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/day10_output_scheduler.sv
// rtl/day10_output_scheduler.sv - round-robin arbiter sharing the day10 output writer among solver lanes
module day10_output_scheduler #(
    parameter int NUM_LANES         = 4,
    parameter int LANE_W            = $clog2(NUM_LANES),
    parameter int MAX_NUM_BUTTONS   = 13,
    parameter int MAX_NUM_BUTTONS_W = $clog2(MAX_NUM_BUTTONS + 1),
    parameter int PRESS_W           = 8,
    parameter int COUNT_W           = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   job_start,
    input  logic [COUNT_W-1:0]                     num_records,
    input  logic [NUM_LANES-1:0]                   lane_result_valid,
    input  logic [NUM_LANES*MAX_NUM_BUTTONS_W-1:0] lane_num_buttons,
    input  logic [NUM_LANES*PRESS_W-1:0]           lane_min_presses,
    input  logic [NUM_LANES*MAX_NUM_BUTTONS-1:0]   lane_buttons_to_press,
    output logic [NUM_LANES-1:0]                   lane_result_ack,
    output logic                                   wr_start,
    output logic                                   wr_last_write,
    input  logic                                   wr_ready,
    output logic [MAX_NUM_BUTTONS_W-1:0]           wr_num_buttons,
    output logic [PRESS_W-1:0]                     wr_min_presses,
    output logic [MAX_NUM_BUTTONS-1:0]             wr_buttons_to_press,
    output logic [LANE_W-1:0]                      grant_lane,
    output logic [COUNT_W-1:0]                     records_written,
    output logic                                   busy,
    output logic                                   done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state, state_next;
    logic [LANE_W-1:0]   rr_ptr;
    logic [COUNT_W-1:0]  job_total;
    logic                arb_found;
    logic [LANE_W-1:0]   arb_idx;
    logic [LANE_W-1:0]   cand_idx;
    logic [LANE_W-1:0]   ptr_next;

    // Search upward from the pointer so the last-granted lane has lowest priority.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand_idx = LANE_W'((int'(rr_ptr) + i) % NUM_LANES);
            if (!arb_found && lane_result_valid[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    assign ptr_next = (arb_idx == LANE_W'(NUM_LANES - 1)) ? '0 : arb_idx + LANE_W'(1);

    always_comb begin
        state_next      = state;
        wr_start        = 1'b0;
        done            = 1'b0;
        busy            = (state != IDLE);
        lane_result_ack = '0;
        case (state)
            IDLE: begin
                if (job_start) begin
                    state_next = (num_records == '0) ? DONE : ARB;
                end
            end
            ARB: begin
                if (arb_found) begin
                    state_next = START;
                end
            end
            START: begin
                wr_start   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (wr_ready) begin
                    lane_result_ack[grant_lane] = 1'b1;
                    state_next = wr_last_write ? DONE : ARB;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Writer-facing data is loaded only at the grant edge and held while the writer streams it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            job_total           <= '0;
            records_written     <= '0;
            grant_lane          <= '0;
            wr_last_write       <= 1'b0;
            wr_num_buttons      <= '0;
            wr_min_presses      <= '0;
            wr_buttons_to_press <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (job_start) begin
                        job_total       <= num_records;
                        records_written <= '0;
                    end
                end
                ARB: begin
                    if (arb_found) begin
                        grant_lane          <= arb_idx;
                        rr_ptr              <= ptr_next;
                        wr_last_write       <= (records_written == job_total - COUNT_W'(1));
                        wr_num_buttons      <= lane_num_buttons[arb_idx*MAX_NUM_BUTTONS_W +: MAX_NUM_BUTTONS_W];
                        wr_min_presses      <= lane_min_presses[arb_idx*PRESS_W +: PRESS_W];
                        wr_buttons_to_press <= lane_buttons_to_press[arb_idx*MAX_NUM_BUTTONS +: MAX_NUM_BUTTONS];
                    end
                end
                WAIT: begin
                    if (wr_ready) begin
                        records_written <= records_written + COUNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
